// File: rtl/costas_byte_ctrl.sv
// costas_byte_ctrl: registers the ADC stream into the costas core and frames, buffers and back-pressures recovered bytes.
// Optional frame watchdog is compiled in when COSTAS_BYTE_CTRL_TIMEOUT_EN is defined.
module costas_byte_ctrl #(
  parameter int DEPTH   = 8,
  parameter int SKID    = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pushADC,
  input  logic [9:0]  ADC,
  output logic        corePushADC,
  output logic [9:0]  coreADC,
  input  logic        corePushByte,
  input  logic [7:0]  coreByte,
  input  logic        coreSync,
  input  logic        coreLastByte,
  output logic        coreStop,
  output logic        pushByte,
  output logic [7:0]  Byte,
  output logic        Sync,
  output logic        lastByte,
  input  logic        stopIn,
  output logic [15:0] frameCnt,
  output logic        overflow,
  output logic        timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_STOP_TH = (AW+1)'(DEPTH - SKID);
  localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  typedef enum logic {ST_HUNT = 1'b0, ST_FRAME = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_next;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_wr_req;
  logic          w_wr;
  logic          w_drop;
  logic          w_to_hit;
  logic          w_timeout;

  logic          r_core_push_adc;
  logic [9:0]    r_core_adc;
  logic          r_core_stop;
  logic          r_push_byte;
  logic [9:0]    r_out;
  logic [15:0]   r_frame_cnt;
  logic          r_overflow;

  // FIFO occupancy, write qualification and pop decision
  always_comb begin
    w_full   = (r_count == C_DEPTH);
    w_empty  = (r_count == {(AW+1){1'b0}});
    w_pop    = !w_empty && !stopIn;
    w_wr_req = corePushByte && ((r_state == ST_FRAME) || coreSync);
    // a full FIFO still accepts the byte when the head leaves on the same edge
    w_wr     = w_wr_req && (!w_full || w_pop);
    w_drop   = w_wr_req && w_full && !w_pop;
    case ({w_wr, w_pop})
      2'b10:   w_count_next = r_count + C_CNT_ONE;
      2'b01:   w_count_next = r_count - C_CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // framing FSM next state; a dropped last byte still ends the frame
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_HUNT: begin
        if (corePushByte && coreSync && !coreLastByte) begin
          w_state_next = ST_FRAME;
        end else begin
          w_state_next = ST_HUNT;
        end
      end
      ST_FRAME: begin
        if ((corePushByte && coreLastByte) || w_to_hit) begin
          w_state_next = ST_HUNT;
        end else begin
          w_state_next = ST_FRAME;
        end
      end
      default: w_state_next = ST_HUNT;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

`ifdef COSTAS_BYTE_CTRL_TIMEOUT_EN
  localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] r_to_cnt;
  logic        r_timeout;

  assign w_to_hit  = (r_state == ST_FRAME) && !corePushByte && pushADC && (r_to_cnt == C_TO_LAST);
  assign w_timeout = r_timeout;

  // watchdog: pushADC samples since the last core byte inside a frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt  <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state != ST_FRAME) || corePushByte || w_to_hit) begin
        r_to_cnt <= 16'd0;
      end else if (pushADC) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end
      if (w_to_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_to_hit  = 1'b0;
  assign w_timeout = 1'b0;
`endif

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {coreLastByte, coreSync, coreByte};
    end
  end

  // pointers, count, ADC pipeline and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr        <= {AW{1'b0}};
      r_rd_ptr        <= {AW{1'b0}};
      r_count         <= {(AW+1){1'b0}};
      r_core_push_adc <= 1'b0;
      r_core_adc      <= 10'd0;
      r_core_stop     <= 1'b0;
      r_push_byte     <= 1'b0;
      r_out           <= 10'd0;
      r_frame_cnt     <= 16'd0;
      r_overflow      <= 1'b0;
    end else begin
      r_core_push_adc <= pushADC;
      r_core_adc      <= ADC;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        r_out    <= r_mem[r_rd_ptr];
        if (r_mem[r_rd_ptr][9]) begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
      end
      r_count     <= w_count_next;
      r_push_byte <= w_pop;
      r_core_stop <= (w_count_next >= C_STOP_TH);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign corePushADC = r_core_push_adc;
  assign coreADC     = r_core_adc;
  assign coreStop    = r_core_stop;
  assign pushByte    = r_push_byte;
  assign Byte        = r_out[7:0];
  assign Sync        = r_out[8];
  assign lastByte    = r_out[9];
  assign frameCnt    = r_frame_cnt;
  assign overflow    = r_overflow;
  assign timeout     = w_timeout;

endmodule

// File: tb/tb_costas_byte_ctrl.sv
// Scoreboard bench for costas_byte_ctrl: a queue-based reference model predicts every cycle and every delivered byte.
// Define COSTAS_BYTE_CTRL_TIMEOUT_EN to also exercise the frame watchdog with TIMEOUT=16.
module tb_costas_byte_ctrl;

  localparam int DEPTH = 8;
  localparam int SKID  = 2;
`ifdef COSTAS_BYTE_CTRL_TIMEOUT_EN
  localparam int TIMEOUT = 16;
`else
  localparam int TIMEOUT = 4096;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        pushADC;
  logic [9:0]  ADC;
  logic        corePushADC;
  logic [9:0]  coreADC;
  logic        corePushByte;
  logic [7:0]  coreByte;
  logic        coreSync;
  logic        coreLastByte;
  logic        coreStop;
  logic        pushByte;
  logic [7:0]  Byte;
  logic        Sync;
  logic        lastByte;
  logic        stopIn;
  logic [15:0] frameCnt;
  logic        overflow;
  logic        timeout;

  costas_byte_ctrl #(.DEPTH(DEPTH), .SKID(SKID), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .pushADC(pushADC), .ADC(ADC),
    .corePushADC(corePushADC), .coreADC(coreADC),
    .corePushByte(corePushByte), .coreByte(coreByte), .coreSync(coreSync),
    .coreLastByte(coreLastByte), .coreStop(coreStop),
    .pushByte(pushByte), .Byte(Byte), .Sync(Sync), .lastByte(lastByte),
    .stopIn(stopIn), .frameCnt(frameCnt), .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        push;
    logic        stop;
    logic        ovf;
    logic        to;
    logic [15:0] frames;
    logic        apush;
    logic [9:0]  adc;
  } exp_t;

  int checks = 0;
  int errors = 0;

  logic [9:0] mq[$];
  logic [9:0] sb[$];
  exp_t       st_q[$];
  bit         m_frame;
  bit         m_ovf;
  bit         m_to;
  int         m_frames;
  int         m_to_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // one clock of stimulus: drive at the falling edge and predict the next rising edge
  task automatic step(input bit pb, input logic [7:0] b, input bit s, input bit l,
                      input bit stp, input bit pa, input logic [9:0] a);
    logic [9:0] e;
    bit         f0;
    bit         popd;
    exp_t       x;
    corePushByte = pb; coreByte = b; coreSync = s; coreLastByte = l;
    stopIn = stp; pushADC = pa; ADC = a;
    f0   = m_frame;
    popd = 1'b0;
    if (mq.size() > 0 && !stp) begin
      e = mq.pop_front();
      sb.push_back(e);
      popd = 1'b1;
      if (e[9]) m_frames++;
    end
    if (pb && (f0 || s)) begin
      if (mq.size() < DEPTH) mq.push_back({l, s, b});
      else m_ovf = 1'b1;
    end
    if (!f0) m_frame = pb && s && !l;
    else if (pb && l) m_frame = 1'b0;
`ifdef COSTAS_BYTE_CTRL_TIMEOUT_EN
    if (!f0 || pb) m_to_cnt = 0;
    else if (pa) begin
      m_to_cnt++;
      if (m_to_cnt == TIMEOUT) begin
        m_frame  = 1'b0;
        m_to     = 1'b1;
        m_to_cnt = 0;
      end
    end
`endif
    x.push   = popd;
    x.stop   = (mq.size() >= DEPTH - SKID);
    x.ovf    = m_ovf;
    x.to     = m_to;
    x.frames = 16'(m_frames);
    x.apush  = pa;
    x.adc    = a;
    st_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit stp);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, stp, 1'($urandom), 10'($urandom));
  endtask

  // asynchronous reset asserted between edges; outputs must clear at once
  task automatic do_reset();
    corePushByte = 1'b0; coreByte = 8'h00; coreSync = 1'b0; coreLastByte = 1'b0;
    stopIn = 1'b0; pushADC = 1'b0; ADC = 10'd0;
    reset = 1'b1;
    #1;
    chk("reset_outputs",
        {8'h00, corePushADC, coreADC, coreStop, pushByte, Byte, Sync, lastByte, overflow, timeout},
        32'h0);
    chk("reset_framecnt", {16'h0, frameCnt}, 32'h0);
    mq.delete(); sb.delete(); st_q.delete();
    m_frame = 1'b0; m_ovf = 1'b0; m_to = 1'b0; m_frames = 0; m_to_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // monitor: per-cycle status plus in-order byte scoreboard
  always @(posedge clk) begin
    exp_t       e;
    logic [9:0] d;
    #1;
    if (!reset && st_q.size() > 0) begin
      e = st_q.pop_front();
      chk("pushByte", {31'h0, pushByte}, {31'h0, e.push});
      chk("coreStop", {31'h0, coreStop}, {31'h0, e.stop});
      chk("overflow", {31'h0, overflow}, {31'h0, e.ovf});
      chk("timeout", {31'h0, timeout}, {31'h0, e.to});
      chk("frameCnt", {16'h0, frameCnt}, {16'h0, e.frames});
      chk("adc_path", {21'h0, corePushADC, coreADC}, {21'h0, e.apush, e.adc});
      if (pushByte) begin
        if (sb.size() == 0) begin
          chk("unexpected_byte", {22'h0, lastByte, Sync, Byte}, 32'hFFFF_FFFF);
        end else begin
          d = sb.pop_front();
          chk("byte_entry", {22'h0, lastByte, Sync, Byte}, {22'h0, d});
        end
      end
    end
  end

  initial begin
    bit pb;
    reset = 1'b0;
    @(negedge clk);
    do_reset();

    // single framed burst
    step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 10'd1);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 10'd2);
    step(1'b1, 8'h7E, 1'b0, 1'b1, 1'b0, 1'b0, 10'd3);
    idle(4, 1'b0);

    // non-sync bytes in HUNT are discarded; single-byte frame
    do_reset();
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    step(1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
    idle(4, 1'b0);

    // fill to DEPTH under downstream stop, then drain
    do_reset();
    for (int i = 0; i < 8; i++)
      step(1'b1, 8'(8'h40 + i), i == 0, i == 7, 1'b1, 1'b0, 10'd0);
    idle(2, 1'b1);
    idle(DEPTH + 3, 1'b0);

    // nine bytes into a stopped FIFO: the ninth is lost
    do_reset();
    for (int i = 0; i < 9; i++)
      step(1'b1, 8'(8'h80 + i), i == 0, i == 8, 1'b1, 1'b0, 10'd0);
    idle(DEPTH + 3, 1'b0);

    // ADC ramp with random core traffic that honours coreStop
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      pb = ($urandom_range(0, 2) == 0) && !coreStop;
      step(pb, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, i[0], 10'(i));
    end
    step(1'b1, 8'hC1, 1'b1, 1'b0, 1'b1, 1'b1, 10'd5);
    step(1'b1, 8'hC2, 1'b0, 1'b0, 1'b1, 1'b0, 10'd6);
    do_reset();
    step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 10'd7);
    step(1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b1, 10'd8);
    idle(4, 1'b0);

`ifdef COSTAS_BYTE_CTRL_TIMEOUT_EN
    // watchdog expiry returns to HUNT; next non-sync byte discarded
    do_reset();
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'(i));
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    idle(4, 1'b0);
`endif

    // random traffic, core sometimes ignoring coreStop
    do_reset();
    for (int i = 0; i < 600; i++) begin
      pb = ($urandom_range(0, 1) == 1) && (!coreStop || $urandom_range(0, 7) == 0);
      step(pb, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, 1'($urandom), 10'($urandom));
    end
    idle(DEPTH + 4, 1'b0);
    chk("scoreboard_drained", sb.size(), 32'd0);
    chk("model_fifo_drained", mq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
